gpt_time_base: RTL and testbench
================================

# gpt_time_base

Parametrised time-base unit for the general-purpose timer: a prescaler, an up/down/center-aligned counter with preloadable auto-reload, and a repetition counter. It generates the update event (UEV) and update-interrupt pulse. It replaces the fixed-width single-mode time base and feeds `cnt_o`/`uev_o` to the capture/compare channels and the CSR block.

## Interface
- `CNT_WIDTH`, 32: width of the counter and the auto-reload value.
- `PSC_WIDTH`, 16: width of the prescaler; the division ratio is `psc+1`.
- `RCR_WIDTH`, 8: width of the repetition counter; UEV occurs every `rcr+1` over/underflows.
- `clk_i` in 1: clock.
- `areset_i` in 1: asynchronous reset, active-high.
- `cen_i` in 1: counter enable (CR1.CEN).
- `dir_i` in 1: edge-mode direction; 0 = up, 1 = down. Ignored in center mode.
- `cms_i` in 2: 00 = edge-aligned; 01/10/11 = center-aligned.
- `arpe_i` in 1: ARR preload enable.
- `udis_i` in 1: update disable.
- `urs_i` in 1: 1 = `uif_o` only from over/underflow.
- `opm_i` in 1: one-pulse mode.
- `ug_i` in 1: software update generation, single-cycle pulse (EGR.UG).
- `arr_i` in CNT_WIDTH: auto-reload value.
- `psc_i` in PSC_WIDTH: prescaler value.
- `rcr_i` in RCR_WIDTH: repetition value.
- `cnt_o` out CNT_WIDTH: counter value.
- `uev_o` out 1: update event, one-cycle pulse.
- `uif_o` out 1: update-interrupt set pulse, one cycle.
- `dir_o` out 1: effective counting direction.
- `tick_o` out 1: prescaled count-enable strobe, combinational.
- `opm_stop_o` out 1: high while halted by one-pulse mode.

## Operation
- **Active values.**
  - `psc_act` and `rcr_act` are shadow registers loaded only at UEV.
  - `arr_act` is `arr_i` when `arpe_i=0`; otherwise it is the shadow loaded at UEV.
- **Run condition.** `run = cen_i & ~opm_stop`.
  - The prescaler counts 0..`psc_act` while `run` is high.
  - `tick_o = run & (psc_cnt == psc_act)`; `psc_cnt` wraps to 0 on that cycle.
- **Edge up**, on tick:
  - If `cnt >= arr_act`: overflow, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- **Edge down**, on tick:
  - If `cnt == 0`: underflow, cnt ← `arr_act`.
  - Otherwise: cnt ← cnt−1.
- **Center mode.** Internal phase register `ph` (0 = up).
  - Up phase, `cnt >= arr_act`: overflow, cnt ← `arr_act`−1, ph ← 1.
  - Down phase, `cnt == 1`: underflow, cnt ← 0, ph ← 0.
  - `arr_act == 0`: cnt holds 0 and every tick is an over/underflow.
  - Sequence for arr=3: 0,1,2,3,2,1,0,1…; events fire on the ticks that leave 3 and arrive at 0.
- **`dir_o`.** Equals `dir_i` in edge mode and `ph` in center mode.
- **Repetition counter**, on each over/underflow:
  - If `rep == 0`: event is qualified, rep ← `rcr_act`.
  - Otherwise: rep ← rep−1.
- **UEV.** Raised by a qualified over/underflow with `udis_i=0`, or by `ug_i` with `udis_i=0`.
  - At the UEV edge: psc/rcr/arr shadows ← inputs; rep ← `rcr_i`.
- **UG.** Regardless of `udis_i`:
  - psc_cnt ← 0.
  - cnt ← `arr_act` in edge down, else 0.
  - ph ← 0.
- **`uif_o`.** Equals `uev_o`, except a UG-caused UEV when `urs_i=1`.
- **One-pulse mode.** With `opm_i=1`, a counter-caused UEV sets `opm_stop`. It clears when `cen_i` is low.
- **Priority:** `areset_i` > `ug_i` > tick. If UG and a tick coincide, the tick is discarded.
- **Arithmetic.** Unsigned modulo-2^width. Lowering ARR below `cnt` with `arpe_i=0` causes overflow on the next up tick (the `>=` compare).

## Timing
- **Reset values:**
  - `cnt_o`=0, `psc_cnt`=0, rep=0.
  - `psc_act`=0, `rcr_act`=0, `arr` shadow = all ones.
  - ph=0, `opm_stop`=0.
  - `uev_o`, `uif_o`, `opm_stop_o` = 0.
  - `dir_o` = `dir_i`.
- **Prescaler latency.** `cen_i` is used directly. With psc=0, `cnt_o` changes on the first clock edge where `cen_i` is sampled high.
- **UEV latency.** `uev_o` and `uif_o` are registered. They are high in the cycle after the event edge, the same cycle `cnt_o` shows the wrapped value. The new shadows govern the very next count.
- **UG latency.** `ug_i` high at edge N gives `uev_o` high in cycle N+1, with `cnt_o` already reinitialised.
- **Mid-operation reset.** All state returns to reset values immediately; no pulse is emitted.

## Test plan
- **Edge up.** psc=1, arr=4, rcr=0, cen=1 → cnt increments every 2 clocks 0..4,0; `uev_o`/`uif_o` one-cycle pulse when cnt becomes 0; period 10 clocks.
- **Edge down with repetition.** psc=0, arr=3, rcr=2 → `uev_o` once per 12 clocks, coincident with cnt reloading to 3.
- **Center mode.** arr=3 → cnt 0,1,2,3,2,1,0; `uev_o` after 3→2 and 1→0; `dir_o` toggles accordingly.
- **Preload.** arpe=1, arr 9→5 written mid-period → current period ends at 9, next ends at 5; with arpe=0 → wraps immediately at ≥5.
- **UG/URS/UDIS.**
  - ug with urs=1 → `uev_o`=1, `uif_o`=0, cnt=0.
  - udis=1 → no `uev_o`, but cnt/psc still reinit.
  - ug coincident with tick → tick lost.
- **OPM and reset.**
  - opm=1, arr=2 → one period then `opm_stop_o`=1 and cnt holds 0 until cen cycles low/high.
  - `areset_i` asserted mid-count → all outputs reset asynchronously.

Source files
------------

// File: rtl/gpt_time_base_if.sv
// Control/status bundle between the timer CSR block and the time-base unit.
// master = CSR/driver side, slave = time base.
interface gpt_time_base_if #(
   parameter int CNT_WIDTH = 32,
   parameter int PSC_WIDTH = 16,
   parameter int RCR_WIDTH = 8
);
   logic                 cen_i;
   logic                 dir_i;
   logic [1:0]           cms_i;
   logic                 arpe_i;
   logic                 udis_i;
   logic                 urs_i;
   logic                 opm_i;
   logic                 ug_i;
   logic [CNT_WIDTH-1:0] arr_i;
   logic [PSC_WIDTH-1:0] psc_i;
   logic [RCR_WIDTH-1:0] rcr_i;
   logic [CNT_WIDTH-1:0] cnt_o;
   logic                 uev_o;
   logic                 uif_o;
   logic                 dir_o;
   logic                 tick_o;
   logic                 opm_stop_o;

   modport master (
      output cen_i, dir_i, cms_i, arpe_i, udis_i, urs_i, opm_i, ug_i,
      output arr_i, psc_i, rcr_i,
      input  cnt_o, uev_o, uif_o, dir_o, tick_o, opm_stop_o
   );

   modport slave (
      input  cen_i, dir_i, cms_i, arpe_i, udis_i, urs_i, opm_i, ug_i,
      input  arr_i, psc_i, rcr_i,
      output cnt_o, uev_o, uif_o, dir_o, tick_o, opm_stop_o
   );
endinterface

// File: rtl/gpt_time_base.sv
// General-purpose timer time base: prescaler, edge/center-aligned counter with
// preloadable auto-reload, repetition counter and update-event generation.
module gpt_time_base #(
   parameter int CNT_WIDTH = 32,
   parameter int PSC_WIDTH = 16,
   parameter int RCR_WIDTH = 8
) (
   input logic             clk_i,
   input logic             areset_i,
   gpt_time_base_if.slave  tmr
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);
   localparam logic [RCR_WIDTH-1:0] RCR_ONE = RCR_WIDTH'(1);

   logic [PSC_WIDTH-1:0] psc_cnt, psc_act;
   logic [RCR_WIDTH-1:0] rep, rcr_act;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt, arr_sh, arr_act;
   logic                 ph, ph_nxt, opm_stop;
   logic                 center, run, tick, ovf, cnt_uev, uev_evt;
   logic                 uev_q, uif_q;

   always_comb begin
      center  = (tmr.cms_i != 2'b00);
      arr_act = tmr.arpe_i ? arr_sh : tmr.arr_i;
      run     = tmr.cen_i & ~opm_stop;
      tick    = run & (psc_cnt == psc_act);
      cnt_nxt = cnt;
      ph_nxt  = ph;
      ovf     = 1'b0;
      if (!center) begin
         if (!tmr.dir_i) begin
            // >= so that lowering ARR below the count wraps on the next tick
            if (cnt >= arr_act) begin
               ovf     = 1'b1;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end else if (cnt == '0) begin
            ovf     = 1'b1;
            cnt_nxt = arr_act;
         end else begin
            cnt_nxt = cnt - CNT_ONE;
         end
      end else if (arr_act == '0) begin
         ovf     = 1'b1;
         cnt_nxt = '0;
         ph_nxt  = 1'b0;
      end else if (!ph) begin
         if (cnt >= arr_act) begin
            ovf     = 1'b1;
            cnt_nxt = arr_act - CNT_ONE;
            ph_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_ONE;
         end
      end else if (cnt <= CNT_ONE) begin
         // <= also catches a down phase entered at 0 when ARR is 1
         ovf     = 1'b1;
         cnt_nxt = '0;
         ph_nxt  = 1'b0;
      end else begin
         cnt_nxt = cnt - CNT_ONE;
      end
      cnt_uev = tick & ~tmr.ug_i & ovf & (rep == '0) & ~tmr.udis_i;
      uev_evt = cnt_uev | (tmr.ug_i & ~tmr.udis_i);
   end

   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         psc_cnt  <= '0;
         psc_act  <= '0;
         rep      <= '0;
         rcr_act  <= '0;
         cnt      <= '0;
         arr_sh   <= '1;
         ph       <= 1'b0;
         opm_stop <= 1'b0;
         uev_q    <= 1'b0;
         uif_q    <= 1'b0;
      end else begin
         uev_q <= uev_evt;
         uif_q <= uev_evt & ~(tmr.ug_i & tmr.urs_i);
         // UG reinitialises the count and swallows any coincident tick
         if (tmr.ug_i) begin
            psc_cnt <= '0;
            cnt     <= (!center && tmr.dir_i) ? arr_act : '0;
            ph      <= 1'b0;
         end else if (run) begin
            psc_cnt <= tick ? '0 : psc_cnt + PSC_ONE;
            if (tick) begin
               cnt <= cnt_nxt;
               ph  <= ph_nxt;
            end
         end
         if (uev_evt) begin
            rep     <= tmr.rcr_i;
            psc_act <= tmr.psc_i;
            rcr_act <= tmr.rcr_i;
            arr_sh  <= tmr.arr_i;
         end else if (tick && !tmr.ug_i && ovf) begin
            rep <= (rep == '0) ? rcr_act : rep - RCR_ONE;
         end
         if (!tmr.cen_i) begin
            opm_stop <= 1'b0;
         end else if (cnt_uev && tmr.opm_i) begin
            opm_stop <= 1'b1;
         end
      end
   end

   assign tmr.cnt_o      = cnt;
   assign tmr.uev_o      = uev_q;
   assign tmr.uif_o      = uif_q;
   assign tmr.dir_o      = center ? ph : tmr.dir_i;
   assign tmr.tick_o     = tick;
   assign tmr.opm_stop_o = opm_stop;

endmodule

// File: tb/tb_gpt_time_base.sv
// Directed bench for gpt_time_base: edge up/down, repetition, center mode,
// preload, UG/URS/UDIS, one-pulse mode and asynchronous reset.
module tb_gpt_time_base;

   localparam int CW = 32;
   localparam int PW = 16;
   localparam int RW = 8;

   logic clk_i = 1'b0;
   logic areset_i;
   int   n_cmp = 0;
   int   n_mis = 0;

   int up_cnt  [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
   bit up_uev  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   int dn_cnt  [12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
   int ctr_cnt [10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
   bit ctr_uev [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
   bit ctr_dir [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
   int pre_cnt [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 0};

   gpt_time_base_if #(.CNT_WIDTH(CW), .PSC_WIDTH(PW), .RCR_WIDTH(RW)) bus ();

   gpt_time_base #(.CNT_WIDTH(CW), .PSC_WIDTH(PW), .RCR_WIDTH(RW)) dut (
      .clk_i    (clk_i),
      .areset_i (areset_i),
      .tmr      (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_w(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic ug_pulse();
      bus.ug_i = 1'b1;
      step();
      bus.ug_i = 1'b0;
   endtask

   initial begin
      areset_i   = 1'b1;
      bus.cen_i  = 1'b0;
      bus.dir_i  = 1'b1;
      bus.cms_i  = 2'b00;
      bus.arpe_i = 1'b0;
      bus.udis_i = 1'b0;
      bus.urs_i  = 1'b0;
      bus.opm_i  = 1'b0;
      bus.ug_i   = 1'b0;
      bus.arr_i  = '0;
      bus.psc_i  = '0;
      bus.rcr_i  = '0;
      #12;
      chk_w("rst_cnt", bus.cnt_o, 0);
      chk_b("rst_uev", bus.uev_o, 1'b0);
      chk_b("rst_uif", bus.uif_o, 1'b0);
      chk_b("rst_opm", bus.opm_stop_o, 1'b0);
      chk_b("rst_dir", bus.dir_o, 1'b1);
      chk_b("rst_tick", bus.tick_o, 1'b0);
      step();
      areset_i  = 1'b0;
      bus.dir_i = 1'b0;

      // edge up, psc=1 arr=4
      bus.psc_i = 16'd1;
      bus.arr_i = 32'd4;
      ug_pulse();
      chk_b("up_ug_uev", bus.uev_o, 1'b1);
      chk_b("up_ug_uif", bus.uif_o, 1'b1);
      chk_w("up_ug_cnt", bus.cnt_o, 0);
      bus.cen_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk_w($sformatf("up_cnt%0d", i), bus.cnt_o, up_cnt[i % 10]);
         chk_b($sformatf("up_uev%0d", i), bus.uev_o, up_uev[i % 10]);
         chk_b($sformatf("up_uif%0d", i), bus.uif_o, up_uev[i % 10]);
         chk_b($sformatf("up_tick%0d", i), bus.tick_o, (i % 2) == 0);
      end
      bus.cen_i = 1'b0;

      // edge down, psc=0 arr=3 rcr=2
      bus.dir_i = 1'b1;
      bus.psc_i = 16'd0;
      bus.arr_i = 32'd3;
      bus.rcr_i = 8'd2;
      ug_pulse();
      chk_w("dn_ug_cnt", bus.cnt_o, 3);
      chk_b("dn_ug_uev", bus.uev_o, 1'b1);
      bus.cen_i = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step();
         chk_w($sformatf("dn_cnt%0d", i), bus.cnt_o, dn_cnt[i % 12]);
         chk_b($sformatf("dn_uev%0d", i), bus.uev_o, (i % 12) == 11);
         chk_b($sformatf("dn_dir%0d", i), bus.dir_o, 1'b1);
      end
      bus.cen_i = 1'b0;
      bus.dir_i = 1'b0;

      // center-aligned, arr=3
      bus.cms_i = 2'b01;
      bus.rcr_i = 8'd0;
      ug_pulse();
      chk_w("ctr_ug_cnt", bus.cnt_o, 0);
      chk_b("ctr_ug_dir", bus.dir_o, 1'b0);
      bus.cen_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_w($sformatf("ctr_cnt%0d", i), bus.cnt_o, ctr_cnt[i]);
         chk_b($sformatf("ctr_uev%0d", i), bus.uev_o, ctr_uev[i]);
         chk_b($sformatf("ctr_dir%0d", i), bus.dir_o, ctr_dir[i]);
      end
      bus.cen_i = 1'b0;
      bus.cms_i = 2'b00;

      // preload: arr 9 -> 5 written mid-period with arpe=1
      bus.arpe_i = 1'b1;
      bus.arr_i  = 32'd9;
      ug_pulse();
      chk_w("pre_ug_cnt", bus.cnt_o, 0);
      bus.cen_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk_w($sformatf("pre_cnt%0d", i), bus.cnt_o, pre_cnt[i]);
         chk_b($sformatf("pre_uev%0d", i), bus.uev_o, (i == 9) || (i == 15));
         if (i == 4) bus.arr_i = 32'd5;
      end
      // no preload: lowering arr below cnt wraps on the next tick
      bus.arpe_i = 1'b0;
      bus.arr_i  = 32'd9;
      for (int i = 0; i < 7; i++) begin
         step();
         chk_w($sformatf("npre_cnt%0d", i), bus.cnt_o, i + 1);
      end
      bus.arr_i = 32'd5;
      step();
      chk_w("npre_wrap_cnt", bus.cnt_o, 0);
      chk_b("npre_wrap_uev", bus.uev_o, 1'b1);

      // UG with URS, coincident with a tick
      bus.arr_i = 32'd9;
      step();
      step();
      step();
      chk_w("ug_pre_cnt", bus.cnt_o, 3);
      bus.ug_i  = 1'b1;
      bus.urs_i = 1'b1;
      step();
      chk_w("ugurs_cnt", bus.cnt_o, 0);
      chk_b("ugurs_uev", bus.uev_o, 1'b1);
      chk_b("ugurs_uif", bus.uif_o, 1'b0);
      bus.ug_i  = 1'b0;
      bus.urs_i = 1'b0;
      step();
      chk_w("ugurs_next_cnt", bus.cnt_o, 1);
      chk_b("ugurs_next_uev", bus.uev_o, 1'b0);
      // UG with UDIS: reinit but no event
      step();
      step();
      chk_w("udis_pre_cnt", bus.cnt_o, 3);
      bus.ug_i   = 1'b1;
      bus.udis_i = 1'b1;
      step();
      chk_w("udis_cnt", bus.cnt_o, 0);
      chk_b("udis_uev", bus.uev_o, 1'b0);
      chk_b("udis_uif", bus.uif_o, 1'b0);
      bus.ug_i   = 1'b0;
      bus.udis_i = 1'b0;
      step();
      chk_w("udis_next_cnt", bus.cnt_o, 1);
      bus.cen_i = 1'b0;

      // one-pulse mode, arr=2
      bus.opm_i = 1'b1;
      bus.arr_i = 32'd2;
      ug_pulse();
      chk_w("opm_ug_cnt", bus.cnt_o, 0);
      bus.cen_i = 1'b1;
      step();
      chk_w("opm_cnt1", bus.cnt_o, 1);
      chk_b("opm_tick1", bus.tick_o, 1'b1);
      step();
      chk_w("opm_cnt2", bus.cnt_o, 2);
      step();
      chk_w("opm_wrap_cnt", bus.cnt_o, 0);
      chk_b("opm_wrap_uev", bus.uev_o, 1'b1);
      chk_b("opm_stop_set", bus.opm_stop_o, 1'b1);
      step();
      chk_w("opm_hold_cnt", bus.cnt_o, 0);
      chk_b("opm_hold_stop", bus.opm_stop_o, 1'b1);
      chk_b("opm_hold_tick", bus.tick_o, 1'b0);
      chk_b("opm_hold_uev", bus.uev_o, 1'b0);
      step();
      chk_w("opm_hold2_cnt", bus.cnt_o, 0);
      bus.cen_i = 1'b0;
      step();
      chk_b("opm_stop_clr", bus.opm_stop_o, 1'b0);
      bus.cen_i = 1'b1;
      step();
      chk_w("opm_restart_cnt", bus.cnt_o, 1);
      step();
      chk_w("opm_restart_cnt2", bus.cnt_o, 2);

      // asynchronous reset mid-count
      areset_i = 1'b1;
      #2;
      chk_w("arst_cnt", bus.cnt_o, 0);
      chk_b("arst_uev", bus.uev_o, 1'b0);
      chk_b("arst_dir", bus.dir_o, 1'b0);
      step();
      areset_i = 1'b0;
      step();
      chk_w("arst2_cnt1", bus.cnt_o, 1);
      step();
      chk_w("arst2_cnt2", bus.cnt_o, 2);
      step();
      chk_b("arst2_uev", bus.uev_o, 1'b1);
      chk_b("arst2_stop", bus.opm_stop_o, 1'b1);
      areset_i = 1'b1;
      #2;
      chk_b("arst_pulse_uev", bus.uev_o, 1'b0);
      chk_b("arst_pulse_uif", bus.uif_o, 1'b0);
      chk_b("arst_pulse_stop", bus.opm_stop_o, 1'b0);
      chk_w("arst_pulse_cnt", bus.cnt_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
